// File: rtl/demux1x2_10_reg.sv
// Registered 1-to-2 demultiplexer: steers a source word into one of two one-entry output
// slots, each with its own valid/ready handshake and a wrapping delivery counter.
module demux1x2_10_reg #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e            a_state_q, a_state_d;
  slot_e            b_state_q, b_state_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  logic a_full, b_full;
  logic a_drain, b_drain;
  logic a_open, b_open;
  logic accept, a_accept, b_accept;

  // Handshake decode. A slot can take a word when empty or when it drains this same cycle.
  always_comb begin
    a_full   = (a_state_q == StFull);
    b_full   = (b_state_q == StFull);
    a_drain  = a_full & a_ready;
    b_drain  = b_full & b_ready;
    a_open   = ~a_full | a_ready;
    b_open   = ~b_full | b_ready;
    in_ready = rst_n & (in_sel ? b_open : a_open);
    accept   = in_valid & in_ready;
    a_accept = accept & ~in_sel;
    b_accept = accept & in_sel;
  end

  // State register (synchronous reset discards any held word).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_state_q <= StEmpty;
      b_state_q <= StEmpty;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  // Next-state logic for both slots.
  always_comb begin
    a_state_d = a_state_q;
    unique case (a_state_q)
      StEmpty: if (a_accept) a_state_d = StFull;
      StFull:  if (a_drain && !a_accept) a_state_d = StEmpty;
      default: a_state_d = StEmpty;
    endcase

    b_state_d = b_state_q;
    unique case (b_state_q)
      StEmpty: if (b_accept) b_state_d = StFull;
      StFull:  if (b_drain && !b_accept) b_state_d = StEmpty;
      default: b_state_d = StEmpty;
    endcase

    // Data only moves on accept, so a stalled word stays stable.
    a_data_d  = a_accept ? in_data : a_data_q;
    b_data_d  = b_accept ? in_data : b_data_q;
    a_count_d = a_drain ? a_count_q + CNT_W'(1) : a_count_q;
    b_count_d = b_drain ? b_count_q + CNT_W'(1) : b_count_q;
  end

  // Outputs.
  always_comb begin
    a_valid = (a_state_q == StFull);
    b_valid = (b_state_q == StFull);
    a_data  = a_data_q;
    b_data  = b_data_q;
    a_count = a_count_q;
    b_count = b_count_q;
  end

endmodule

// File: tb/tb_demux1x2_10_reg.sv
// Self-checking bench for demux1x2_10_reg: directed vector table, hand sequences for
// streaming / wrap / mid-run reset, and random traffic against a queue-based model.
module tb_demux1x2_10_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [9:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] a_count;
  logic [7:0] b_count;

  int checks = 0;
  int errors = 0;

  demux1x2_10_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  // Reference model: each destination is a FIFO of at most one word.
  int unsigned qa[$];
  int unsigned qb[$];
  int unsigned ma_data, mb_data, ma_cnt, mb_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (!rst_n) return 1'b0;
    if (in_sel) return (qb.size() == 0) || b_ready;
    return (qa.size() == 0) || a_ready;
  endfunction

  task automatic model_check();
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    chk("m_a_valid", {31'd0, a_valid}, (qa.size() != 0) ? 1 : 0);
    chk("m_b_valid", {31'd0, b_valid}, (qb.size() != 0) ? 1 : 0);
    chk("m_a_data", {22'd0, a_data}, (qa.size() != 0) ? qa[0] : ma_data);
    chk("m_b_data", {22'd0, b_data}, (qb.size() != 0) ? qb[0] : mb_data);
    chk("m_a_count", {24'd0, a_count}, ma_cnt);
    chk("m_b_count", {24'd0, b_count}, mb_cnt);
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && model_ready();
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      ma_data = 0;
      mb_data = 0;
      ma_cnt  = 0;
      mb_cnt  = 0;
    end else begin
      if (qa.size() != 0 && a_ready) begin
        void'(qa.pop_front());
        ma_cnt = (ma_cnt + 1) % 256;
      end
      if (qb.size() != 0 && b_ready) begin
        void'(qb.pop_front());
        mb_cnt = (mb_cnt + 1) % 256;
      end
      if (acc) begin
        if (in_sel) begin
          qb.push_back(in_data);
          mb_data = in_data;
        end else begin
          qa.push_back(in_data);
          ma_data = in_data;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit s, input logic [9:0] d,
                       input bit ar, input bit br);
    rst_n    = r;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit r, input bit v, input bit s, input logic [9:0] d,
                      input bit ar, input bit br, output logic ir);
    drive(r, v, s, d, ar, br);
    ir = in_ready;
    model_check();
    advance();
  endtask

  typedef struct {
    bit r, v, s; logic [9:0] d; bit ar, br;
    bit ir, av; logic [9:0] ad; bit bv; logic [9:0] bd; int ac, bc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic ir;
    // Expected values are what is seen during the cycle, before the next edge.
    tbl[0]  = '{0, 1, 0, 10'h3FF, 1, 1,  0, 0, 10'h000, 0, 10'h000, 0, 0};
    tbl[1]  = '{0, 1, 0, 10'h3FF, 1, 1,  0, 0, 10'h000, 0, 10'h000, 0, 0};
    tbl[2]  = '{1, 1, 0, 10'h155, 1, 1,  1, 0, 10'h000, 0, 10'h000, 0, 0};
    tbl[3]  = '{1, 1, 1, 10'h2AA, 1, 1,  1, 1, 10'h155, 0, 10'h000, 0, 0};
    tbl[4]  = '{1, 0, 0, 10'h000, 1, 1,  1, 0, 10'h155, 1, 10'h2AA, 1, 0};
    tbl[5]  = '{1, 0, 0, 10'h000, 1, 1,  1, 0, 10'h155, 0, 10'h2AA, 1, 1};
    tbl[6]  = '{1, 1, 0, 10'h001, 0, 1,  1, 0, 10'h155, 0, 10'h2AA, 1, 1};
    tbl[7]  = '{1, 1, 0, 10'h002, 0, 1,  0, 1, 10'h001, 0, 10'h2AA, 1, 1};
    tbl[8]  = '{1, 1, 0, 10'h002, 0, 1,  0, 1, 10'h001, 0, 10'h2AA, 1, 1};
    tbl[9]  = '{1, 1, 0, 10'h002, 1, 1,  1, 1, 10'h001, 0, 10'h2AA, 1, 1};
    tbl[10] = '{1, 0, 0, 10'h000, 0, 1,  0, 1, 10'h002, 0, 10'h2AA, 2, 1};
    tbl[11] = '{1, 1, 1, 10'h0F0, 0, 1,  1, 1, 10'h002, 0, 10'h2AA, 2, 1};
    tbl[12] = '{1, 0, 1, 10'h000, 0, 0,  0, 1, 10'h002, 1, 10'h0F0, 2, 1};
    tbl[13] = '{1, 0, 0, 10'h000, 1, 1,  1, 1, 10'h002, 1, 10'h0F0, 2, 1};
    tbl[14] = '{1, 0, 0, 10'h000, 0, 0,  1, 0, 10'h002, 0, 10'h0F0, 3, 2};
    tbl[15] = '{1, 0, 1, 10'h000, 1, 1,  1, 0, 10'h002, 0, 10'h0F0, 3, 2};
    tbl[16] = '{1, 0, 0, 10'h000, 0, 0,  1, 0, 10'h002, 0, 10'h0F0, 3, 2};

    // Bring registers out of X with one reset edge; model starts in its reset state.
    drive(0, 0, 0, 10'h000, 0, 0);
    model_step();
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
      chk($sformatf("t%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
      chk($sformatf("t%0d_a_valid", i), {31'd0, a_valid}, {31'd0, tbl[i].av});
      chk($sformatf("t%0d_a_data", i), {22'd0, a_data}, {22'd0, tbl[i].ad});
      chk($sformatf("t%0d_b_valid", i), {31'd0, b_valid}, {31'd0, tbl[i].bv});
      chk($sformatf("t%0d_b_data", i), {22'd0, b_data}, {22'd0, tbl[i].bd});
      chk($sformatf("t%0d_a_count", i), {24'd0, a_count}, tbl[i].ac);
      chk($sformatf("t%0d_b_count", i), {24'd0, b_count}, tbl[i].bc);
      model_check();
      advance();
    end

    // Streaming: 20 alternating words, readies high, no stall expected.
    tick(0, 0, 0, 10'h000, 1, 1, ir);
    for (int i = 0; i < 20; i++) begin
      tick(1, 1, i[0], 10'h100 + 10'(i), 1, 1, ir);
      chk("stream_in_ready", {31'd0, ir}, 1);
    end
    tick(1, 0, 0, 10'h000, 1, 1, ir);
    chk("stream_a_count", {24'd0, a_count}, 10);
    chk("stream_b_count", {24'd0, b_count}, 10);
    chk("stream_a_last", {22'd0, a_data}, 10'h112);
    chk("stream_b_last", {22'd0, b_data}, 10'h113);

    // Counter wrap on B after 256 deliveries.
    tick(0, 0, 0, 10'h000, 1, 1, ir);
    for (int i = 0; i < 256; i++) tick(1, 1, 1, 10'(i), 0, 1, ir);
    chk("wrap_b_count_255", {24'd0, b_count}, 255);
    tick(1, 0, 1, 10'h000, 0, 1, ir);
    chk("wrap_b_count_0", {24'd0, b_count}, 0);
    chk("wrap_b_valid", {31'd0, b_valid}, 0);

    // Mid-run reset with A full and a pending drain discards everything.
    tick(1, 1, 1, 10'h011, 0, 1, ir);
    tick(1, 1, 0, 10'h3C3, 0, 1, ir);
    chk("pre_rst_a_valid", {31'd0, a_valid}, 1);
    chk("pre_rst_b_count", {24'd0, b_count}, 1);
    tick(0, 1, 0, 10'h155, 1, 1, ir);
    chk("rst_in_ready", {31'd0, ir}, 0);
    chk("rst_a_valid", {31'd0, a_valid}, 0);
    chk("rst_a_data", {22'd0, a_data}, 0);
    chk("rst_a_count", {24'd0, a_count}, 0);
    chk("rst_b_count", {24'd0, b_count}, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 63) != 0), $urandom_range(0, 3) != 0, 1'($urandom),
           10'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ir);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1x2_10_reg.md
Name: demux1x2_10_reg

Overview:
- Registered 1-to-2 demultiplexer for the 10-bit datapath. It is the distribution-side counterpart of the 2:1 word select.
- Steers one 10-bit source word to destination A or B under a select bit.
- Each destination has a one-entry output register with a valid/ready handshake, so producer and consumers are decoupled by one pipeline stage.
- Per-destination delivery counters support debug and verification.

Parameters:
WIDTH, 10, data word width
CNT_W, 8, width of per-port delivery counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  WIDTH  source word
in_sel  input  1  destination select: 0 = A, 1 = B
in_valid  input  1  source word valid
in_ready  output  1  block accepts word this cycle
a_data  output  WIDTH  port A word (registered)
a_valid  output  1  port A holds a word
a_ready  input  1  port A consumer accepts
b_data  output  WIDTH  port B word (registered)
b_valid  output  1  port B holds a word
b_ready  input  1  port B consumer accepts
a_count  output  CNT_W  words delivered on A (a_valid & a_ready), wraps
b_count  output  CNT_W  words delivered on B, wraps

Behaviour:
- Reset: synchronous, sampled on rising clk while rst_n = 0.
  - Clears a_valid, b_valid, a_data, b_data, a_count, b_count to 0.
  - in_ready is combinational and low during reset.
  - Reset mid-transfer discards held words; no handshake completes in a reset cycle.
- Per-port slot state (X = A or B): EMPTY (X_valid = 0) or FULL (X_valid = 1).
  - EMPTY -> FULL on accept for X.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain + accept in the same cycle; the register is overwritten with the new word.
  - FULL -> FULL on no drain; data held stable, must not change while X_valid = 1 and X_ready = 0.
- in_ready = rst_n & (in_sel ? (!b_valid | b_ready) : (!a_valid | a_ready)).
  - Depends on in_sel, and on the selected port's ready input for the pass-through case.
  - No combinational path from in_data.
- Accept = in_valid & in_ready.
  - The word is registered into the port chosen by in_sel.
  - It appears on X_data/X_valid the cycle after accept: latency 1.
  - Sustained throughput is 1 word/cycle to either port when the consumer holds ready high.
- The unselected port is unaffected by the input. It drains independently whenever its own valid & ready is high.
- Simultaneous drain of A and B in the same cycle is allowed; both counters increment.
- Counters:
  - X_count increments by 1 on each X_valid & X_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- in_valid = 0: no slot state change, except drains.
- in_sel with in_valid = 0 is don't-care; in_ready still reflects the selected port.
- Consumers may assert X_ready while X_valid = 0; this has no effect and no count.
- Ordering:
  - Words to the same port are delivered in acceptance order.
  - No ordering guarantee across ports.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1, in_data = 10'h3FF -> a_valid = b_valid = 0, counts = 0, in_ready = 0; first accept only after rst_n = 1.
- Basic steer: a_ready = b_ready = 1; send 10'h155 sel = 0, then 10'h2AA sel = 1 -> a_data = 10'h155 one cycle after first accept, b_data = 10'h2AA one cycle after second; a_count = 1, b_count = 1.
- Backpressure: a_ready = 0; send 10'h001 sel = 0, then offer 10'h002 sel = 0.
  - in_ready drops, a_data holds 10'h001.
  - Raise a_ready -> 10'h001 delivered; 10'h002 accepted the same cycle (pass-through) and delivered next cycle.
- Independent ports: a_ready = 0 with A full; send 10'h0F0 sel = 1 -> accepted, b_valid next cycle, A still holds its word.
- Streaming: 20 back-to-back words alternating sel, both readies high -> in_ready constantly 1; a_count = 10, b_count = 10, data in order per port.
- Counter wrap and reset mid-operation: CNT_W = 8, deliver 256 words on B -> b_count = 0.
  - Then fill A with a_ready = 0 and pulse rst_n low for 1 cycle -> a_valid = 0, counts = 0, no delivery recorded.
